// File: rtl/fifo_rd_chk_pkg.sv
// Shared types and defaults for the FIFO read-side frame checker.
// Optional stop-on-first-error behaviour is selected with FIFO_RD_CHK_STOP_ON_ERR_EN.
package fifo_rd_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int DEFAULT_W     = 16;
  localparam int DEFAULT_STEP  = 5;
  localparam int DEFAULT_LEN_W = 8;

  localparam logic [DEFAULT_LEN_W-1:0] ERR_IDX_NONE = '1;

endpackage

// File: rtl/fifo_rd_chk_patgen.sv
// Running expected-value generator: holds i*STEP mod 2^W as an accumulator,
// so the checker never needs a multiplier.
module fifo_rd_chk_patgen
  import fifo_rd_chk_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter int STEP = DEFAULT_STEP
) (
  input  logic         read_clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] exp_val
);

  logic [W-1:0] exp_val_d;
  logic [W-1:0] exp_val_q;

  always_comb begin
    exp_val_d = exp_val_q;
    if (clear) begin
      exp_val_d = '0;
    end else if (advance) begin
      exp_val_d = exp_val_q + W'(STEP);
    end
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_val_q <= '0;
    end else begin
      exp_val_q <= exp_val_d;
    end
  end

  assign exp_val = exp_val_q;

endmodule

// File: rtl/fifo_rd_checker.sv
// Drains a fixed-length frame from a show-ahead FIFO read port and checks each
// word against the i*STEP pattern. Define FIFO_RD_CHK_STOP_ON_ERR_EN to end the frame on the first mismatch.
module fifo_rd_checker
  import fifo_rd_chk_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int STEP  = DEFAULT_STEP,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             read_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             r_empty,
  input  logic [W-1:0]     rd_data,
  output logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] word_cnt,
  output logic [LEN_W-1:0] err_cnt,
  output logic [LEN_W-1:0] first_err_idx
);

  localparam logic [LEN_W-1:0] IDX_NONE = '1;

  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] err_cnt_q, err_cnt_d;
  logic [LEN_W-1:0] first_err_q, first_err_d;

  logic [W-1:0] exp_val;
  logic         start_acc;
  logic         pop;
  logic         mismatch;
  logic         last_word;
  logic         stop_now;

  assign start_acc = (state_q == IDLE) && start;
  assign pop       = (state_q == RUN) && !r_empty;
  assign mismatch  = pop && (rd_data != exp_val);
  assign last_word = pop && ((word_cnt_q + LEN_W'(1)) == len_q);

`ifdef FIFO_RD_CHK_STOP_ON_ERR_EN
  assign stop_now = last_word || mismatch;
`else
  assign stop_now = last_word;
`endif

  fifo_rd_chk_patgen #(
    .W    (W),
    .STEP (STEP)
  ) u_patgen (
    .read_clk (read_clk),
    .reset_n  (reset_n),
    .clear    (start_acc),
    .advance  (pop),
    .exp_val  (exp_val)
  );

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero-length start skips RUN entirely so done still pulses exactly once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (frame_len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (stop_now) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_en = pop;
    busy  = (state_q != IDLE);
    done  = (state_q == FIN);
  end

  // err_cnt never returns to zero inside a frame, so zero marks "no error yet".
  always_comb begin
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (start_acc) begin
      len_d       = frame_len;
      word_cnt_d  = '0;
      err_cnt_d   = '0;
      first_err_d = IDX_NONE;
    end else if (pop) begin
      word_cnt_d = word_cnt_q + LEN_W'(1);
      if (mismatch) begin
        if (err_cnt_q != IDX_NONE) begin
          err_cnt_d = err_cnt_q + LEN_W'(1);
        end
        if (err_cnt_q == '0) begin
          first_err_d = word_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= IDX_NONE;
    end else begin
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign word_cnt      = word_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: a queue models the show-ahead FIFO for the
// 16-bit instance, and an ideal pattern source feeds a second 8-bit instance.
module tb_fifo_rd_checker;

  logic        read_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  frame_len;
  logic        r_empty;
  logic [15:0] rd_data;
  logic        rd_en, busy, done;
  logic [7:0]  word_cnt, err_cnt, first_err_idx;

  logic        start8;
  logic [7:0]  frame_len8;
  logic        r_empty8;
  logic [7:0]  rd_data8;
  logic        rd_en8, busy8, done8;
  logic [7:0]  word_cnt8, err_cnt8, first_err_idx8;

  int errors = 0;
  int checks = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] popped[$];
  bit          stall = 1'b0;
  bit          stall_mode = 1'b0;
  int          cyc = 0;
  int          done_seen = 0;
  int          done8_seen = 0;
  int          empty_viol = 0;
  int          idx8 = 0;

  fifo_rd_checker dut (
    .read_clk      (read_clk),
    .reset_n       (reset_n),
    .start         (start),
    .frame_len     (frame_len),
    .r_empty       (r_empty),
    .rd_data       (rd_data),
    .rd_en         (rd_en),
    .busy          (busy),
    .done          (done),
    .word_cnt      (word_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  fifo_rd_checker #(.W(8), .STEP(5), .LEN_W(8)) dut8 (
    .read_clk      (read_clk),
    .reset_n       (reset_n),
    .start         (start8),
    .frame_len     (frame_len8),
    .r_empty       (r_empty8),
    .rd_data       (rd_data8),
    .rd_en         (rd_en8),
    .busy          (busy8),
    .done          (done8),
    .word_cnt      (word_cnt8),
    .err_cnt       (err_cnt8),
    .first_err_idx (first_err_idx8)
  );

  always #5 read_clk = ~read_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    r_empty  = stall || (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    r_empty8 = 1'b0;
    rd_data8 = 8'(idx8 * 5);
  endtask

  // One clock: observe strobes at the falling edge, apply pops just after the rising edge.
  task automatic tick();
    bit pop, pop8;
    @(negedge read_clk);
    if (rd_en && r_empty) empty_viol++;
    if (done) done_seen++;
    if (done8) done8_seen++;
    pop  = rd_en;
    pop8 = rd_en8;
    @(posedge read_clk);
    #1;
    if (pop && fifo_q.size() != 0) popped.push_back(fifo_q.pop_front());
    if (pop8) idx8++;
    cyc++;
    if (stall_mode) stall = ((cyc / 3) % 2) == 1;
    refresh();
  endtask

  task automatic pulse_start(input logic [7:0] len);
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget, output int used);
    int d0;
    d0 = done_seen;
    used = 0;
    while (done_seen == d0 && used < budget) begin
      tick();
      used++;
    end
    check({tag, "_done"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    int used;
    int bad;
    int d0;
    reset_n = 1'b0;
    start = 1'b0;
    frame_len = 8'd0;
    start8 = 1'b0;
    frame_len8 = 8'd0;
    refresh();
    tick();
    tick();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_first_err", 32'(first_err_idx), 32'd255);
    reset_n = 1'b1;
    tick();

    // Clean frame of 32 words, no stalls: 32 consecutive pops then done.
    for (int i = 0; i < 32; i++) fifo_q.push_back(16'(i * 5));
    popped.delete();
    refresh();
    pulse_start(8'd32);
    check("t1_busy", 32'(busy), 32'd1);
    run_until_done("t1", 100, used);
    check("t1_cycles", 32'(used), 32'd33);
    check("t1_word_cnt", 32'(word_cnt), 32'd32);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_first_err", 32'(first_err_idx), 32'd255);
    check("t1_pops", 32'(popped.size()), 32'd32);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Frame of 10 with r_empty toggling every 3 cycles.
    for (int i = 0; i < 10; i++) fifo_q.push_back(16'(i * 5));
    popped.delete();
    empty_viol = 0;
    stall_mode = 1'b1;
    refresh();
    pulse_start(8'd10);
    run_until_done("t2", 200, used);
    stall_mode = 1'b0;
    stall = 1'b0;
    refresh();
    check("t2_empty_viol", 32'(empty_viol), 32'd0);
    check("t2_word_cnt", 32'(word_cnt), 32'd10);
    check("t2_err_cnt", 32'(err_cnt), 32'd0);
    bad = 0;
    foreach (popped[i]) if (popped[i] !== 16'(i * 5)) bad++;
    check("t2_order", 32'(bad), 32'd0);
    check("t2_pops", 32'(popped.size()), 32'd10);

    // Word 7 corrupted in a 16-word frame.
    for (int i = 0; i < 16; i++) fifo_q.push_back((i == 7) ? 16'hFFFF : 16'(i * 5));
    popped.delete();
    refresh();
    pulse_start(8'd16);
    run_until_done("t3", 100, used);
    check("t3_err_cnt", 32'(err_cnt), 32'd1);
    check("t3_first_err", 32'(first_err_idx), 32'd7);
`ifdef FIFO_RD_CHK_STOP_ON_ERR_EN
    check("t3_word_cnt", 32'(word_cnt), 32'd8);
    check("t3_pops", 32'(popped.size()), 32'd8);
    check("t3_cycles", 32'(used), 32'd9);
`else
    check("t3_word_cnt", 32'(word_cnt), 32'd16);
    check("t3_pops", 32'(popped.size()), 32'd16);
    check("t3_cycles", 32'(used), 32'd17);
`endif
    fifo_q.delete();
    refresh();

    // Full 255-word frame; last expected value 254*5 = 1270.
    for (int i = 0; i < 255; i++) fifo_q.push_back(16'(i * 5));
    popped.delete();
    refresh();
    pulse_start(8'd255);
    run_until_done("t4", 400, used);
    check("t4_word_cnt", 32'(word_cnt), 32'd255);
    check("t4_err_cnt", 32'(err_cnt), 32'd0);
    check("t4_first_err", 32'(first_err_idx), 32'd255);
    check("t4_last_val", 32'(popped[popped.size() - 1]), 32'd1270);

    // 8-bit instance: pattern wraps 255 -> 4 at word 52.
    idx8 = 0;
    refresh();
    start8 = 1'b1;
    frame_len8 = 8'd60;
    tick();
    start8 = 1'b0;
    d0 = done8_seen;
    used = 0;
    while (done8_seen == d0 && used < 200) begin
      tick();
      used++;
    end
    check("t4w8_done", 32'(done8_seen - d0), 32'd1);
    check("t4w8_word_cnt", 32'(word_cnt8), 32'd60);
    check("t4w8_err_cnt", 32'(err_cnt8), 32'd0);
    check("t4w8_first_err", 32'(first_err_idx8), 32'd255);

    // Zero-length frame: done the very next cycle, the waiting word stays put.
    fifo_q.push_back(16'h1234);
    popped.delete();
    refresh();
    pulse_start(8'd0);
    check("t5_zero_done", 32'(done), 32'd1);
    check("t5_zero_rd_en", 32'(rd_en), 32'd0);
    tick();
    check("t5_zero_done_off", 32'(done), 32'd0);
    check("t5_zero_pops", 32'(popped.size()), 32'd0);
    fifo_q.delete();
    refresh();

    // start while busy must not restart the frame.
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'(i * 5));
    stall = 1'b1;
    refresh();
    pulse_start(8'd6);
    stall = 1'b0;
    refresh();
    tick();
    tick();
    stall = 1'b1;
    refresh();
    pulse_start(8'd3);
    check("t5_busy_word_cnt", 32'(word_cnt), 32'd2);
    check("t5_busy_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    refresh();
    run_until_done("t5_busy", 50, used);
    check("t5_busy_final_cnt", 32'(word_cnt), 32'd6);
    check("t5_busy_err_cnt", 32'(err_cnt), 32'd0);

    // Reset after 5 pops of a 20-word frame aborts with no done pulse.
    for (int i = 0; i < 20; i++) fifo_q.push_back(16'(i * 5));
    popped.delete();
    refresh();
    pulse_start(8'd20);
    for (int i = 0; i < 5; i++) tick();
    check("t6_pre_word_cnt", 32'(word_cnt), 32'd5);
    d0 = done_seen;
    reset_n = 1'b0;
    #1;
    check("t6_rst_word_cnt", 32'(word_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rd_en", 32'(rd_en), 32'd0);
    check("t6_rst_first_err", 32'(first_err_idx), 32'd255);
    tick();
    tick();
    check("t6_no_done", 32'(done_seen - d0), 32'd0);
    reset_n = 1'b1;
    fifo_q.delete();
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'(i * 5));
    popped.delete();
    refresh();
    tick();
    pulse_start(8'd4);
    check("t6_restart_cnt0", 32'(word_cnt), 32'd0);
    run_until_done("t6", 50, used);
    check("t6_word_cnt", 32'(word_cnt), 32'd4);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_first_err", 32'(first_err_idx), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
